// File: rtl/axi_vga_lite_regs.sv
// axi_vga_lite_regs: AXI4-Lite slave register file exporting its registers to the VGA timing/colour logic.
// AW and W are buffered independently; a write commits once both buffers are full and no response is pending.
module axi_vga_lite_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    localparam int N = 2 ** (C_S_AXI_ADDR_WIDTH - 2)
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [32*N-1:0]                 REG_OUT,
    output logic [N-1:0]                    REG_WR_STB
);
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    logic            aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic            bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic            awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic [IW-1:0]   aw_idx_q, aw_idx_d;
    logic [DW-1:0]   w_data_q, w_data_d, rdata_q, rdata_d;
    logic [DW/8-1:0] w_strb_q, w_strb_d;
    logic [N-1:0]    wr_stb_q, wr_stb_d;
    logic [DW-1:0]   regs_q [N];
    logic [DW-1:0]   regs_d [N];
    logic            aw_hs, w_hs, ar_hs, commit, unused_ok;

    assign aw_hs  = S_AXI_AWVALID & awready_q;
    assign w_hs   = S_AXI_WVALID & wready_q;
    assign ar_hs  = S_AXI_ARVALID & arready_q;
    assign commit = aw_full_q & w_full_q & ~bvalid_q;
    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Ready flags are registered copies of the next-state condition so they are low during reset.
    always_comb begin
        aw_full_d = commit ? 1'b0 : (aw_full_q | aw_hs);
        aw_idx_d  = aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : aw_idx_q;
        w_full_d  = commit ? 1'b0 : (w_full_q | w_hs);
        w_data_d  = w_hs ? S_AXI_WDATA : w_data_q;
        w_strb_d  = w_hs ? S_AXI_WSTRB : w_strb_q;
        bvalid_d  = commit | (bvalid_q & ~S_AXI_BREADY);
        awready_d = ~aw_full_d & ~bvalid_d;
        wready_d  = ~w_full_d & ~bvalid_d;
        rvalid_d  = ar_hs | (rvalid_q & ~S_AXI_RREADY);
        arready_d = ~rvalid_d;
        rdata_d   = ar_hs ? regs_q[S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]] : rdata_q;
        wr_stb_d  = commit ? (N'(1) << aw_idx_q) : '0;
        for (int k = 0; k < N; k++) begin
            regs_d[k] = regs_q[k];
            for (int i = 0; i < DW/8; i++)
                if (commit && aw_idx_q == IW'(k) && w_strb_q[i]) regs_d[k][8*i +: 8] = w_data_q[8*i +: 8];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            aw_idx_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            rdata_q   <= '0;
            wr_stb_q  <= '0;
            for (int k = 0; k < N; k++) regs_q[k] <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            aw_idx_q  <= aw_idx_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            rdata_q   <= rdata_d;
            wr_stb_q  <= wr_stb_d;
            for (int k = 0; k < N; k++) regs_q[k] <= regs_d[k];
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign REG_WR_STB    = wr_stb_q;

    for (genvar g = 0; g < N; g++) begin : g_out
        assign REG_OUT[32*g +: 32] = regs_q[g];
    end
endmodule

// File: tb/tb_axi_vga_lite_regs.sv
// tb_axi_vga_lite_regs: scoreboard bench; stimulus pushes expected B/R/strobe events, a negedge monitor pops and compares.
module tb_axi_vga_lite_regs;
    localparam int AW = 4;
    localparam int N = 4;
    logic ACLK = 1'b0, ARESETN = 1'b0;
    logic [AW-1:0] AWADDR = '0, ARADDR = '0;
    logic AWVALID = 0, WVALID = 0, BREADY = 1, ARVALID = 0, RREADY = 1;
    logic [31:0] WDATA = '0;
    logic [3:0] WSTRB = '0;
    logic AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0] BRESP, RRESP;
    logic [31:0] RDATA;
    logic [32*N-1:0] REG_OUT;
    logic [N-1:0] REG_WR_STB;

    int n_cmp = 0, n_bad = 0;
    logic [31:0] model [N];
    logic [31:0] rq [$];
    logic [N-1:0] sq [$];
    int bq = 0;

    axi_vga_lite_regs dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
        .REG_OUT(REG_OUT), .REG_WR_STB(REG_WR_STB)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: handshake did not occur within cycle budget", nm);
    endtask

    // Monitor: every completed B/R handshake and every strobe pulse must match a queued expectation.
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (BVALID && BREADY) begin
                if (bq == 0) chk("b_unexpected", 32'(BVALID), 0);
                else begin
                    bq--;
                    chk("bresp", 32'(BRESP), 0);
                end
            end
            if (RVALID && RREADY) begin
                if (rq.size() == 0) chk("r_unexpected", 32'(RVALID), 0);
                else begin
                    chk("rdata", RDATA, rq.pop_front());
                    chk("rresp", 32'(RRESP), 0);
                end
            end
            if (REG_WR_STB != '0) begin
                if (sq.size() == 0) chk("stb_unexpected", 32'(REG_WR_STB), 0);
                else chk("reg_wr_stb", 32'(REG_WR_STB), 32'(sq.pop_front()));
            end
        end
    end

    task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) model[a[3:2]][8*i +: 8] = d[8*i +: 8];
        bq++;
        sq.push_back(N'(1) << a[3:2]);
    endtask

    task automatic wr_req(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_lag, input int w_lag);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0;
        while (!(aw_done && w_done)) begin
            if (!aw_done && cyc >= aw_lag) begin AWVALID = 1; AWADDR = a; end
            if (!w_done && cyc >= w_lag) begin WVALID = 1; WDATA = d; WSTRB = s; end
            @(negedge ACLK);
            aw_hs = AWVALID && AWREADY;
            w_hs = WVALID && WREADY;
            @(posedge ACLK); #1;
            if (aw_hs) begin aw_done = 1; AWVALID = 0; end
            if (w_hs) begin w_done = 1; WVALID = 0; end
            cyc++;
            if (cyc > 60) begin
                timeout("aw_w_accept");
                AWVALID = 0;
                WVALID = 0;
                return;
            end
        end
        model_write(a, d, s);
    endtask

    task automatic wait_b(input int hold);
        bit seen;
        if (hold > 0) begin
            BREADY = 0;
            repeat (hold) begin @(posedge ACLK); #1; end
        end
        BREADY = 1;
        for (int c = 0; c < 60; c++) begin
            @(negedge ACLK);
            seen = BVALID;
            @(posedge ACLK); #1;
            if (seen) return;
        end
        timeout("b_wait");
    endtask

    task automatic rd_req(input logic [AW-1:0] a);
        bit hs;
        ARVALID = 1;
        ARADDR = a;
        for (int c = 0; c < 60; c++) begin
            @(negedge ACLK);
            hs = ARREADY;
            @(posedge ACLK); #1;
            if (hs) begin
                ARVALID = 0;
                rq.push_back(model[a[3:2]]);
                return;
            end
        end
        ARVALID = 0;
        timeout("ar_accept");
    endtask

    task automatic wait_r(input int hold);
        bit seen;
        if (hold > 0) begin
            RREADY = 0;
            repeat (hold) begin @(posedge ACLK); #1; end
        end
        RREADY = 1;
        for (int c = 0; c < 60; c++) begin
            @(negedge ACLK);
            seen = RVALID;
            @(posedge ACLK); #1;
            if (seen) return;
        end
        timeout("r_wait");
    endtask

    task automatic chk_regout();
        for (int k = 0; k < N; k++) chk($sformatf("reg_out%0d", k), REG_OUT[32*k +: 32], model[k]);
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_req(a, d, s, 0, 0);
        wait_b(0);
        chk_regout();
    endtask

    task automatic read(input logic [AW-1:0] a);
        rd_req(a);
        wait_r(0);
    endtask

    task automatic chk_idle_zero(input string nm);
        chk({nm, "_awready"}, 32'(AWREADY), 0);
        chk({nm, "_wready"}, 32'(WREADY), 0);
        chk({nm, "_arready"}, 32'(ARREADY), 0);
        chk({nm, "_bvalid"}, 32'(BVALID), 0);
        chk({nm, "_rvalid"}, 32'(RVALID), 0);
        chk({nm, "_rdata"}, RDATA, 0);
        chk({nm, "_stb"}, 32'(REG_WR_STB), 0);
        chk_regout();
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [31:0] d;
        for (int k = 0; k < N; k++) model[k] = '0;
        #12 chk_idle_zero("reset");
        #10 ARESETN = 1;
        @(posedge ACLK); #1;

        write(4'h0, 32'h0101FFFF, 4'hf);
        write(4'h4, 32'habcd0001, 4'hf);
        write(4'h8, 32'hdead0011, 4'hf);
        write(4'hC, 32'hbeef0011, 4'hf);
        for (int k = 0; k < N; k++) read(AW'(4 * k));

        write(4'h4, 32'h11223344, 4'b0101);
        read(4'h4);

        // W arrives well ahead of AW
        WVALID = 1; WDATA = 32'h5a5a5a5a; WSTRB = 4'hf;
        @(negedge ACLK); chk("t3_wready_pre", 32'(WREADY), 1);
        @(posedge ACLK); #1 WVALID = 0;
        repeat (2) begin
            @(negedge ACLK); chk("t3_wready_low", 32'(WREADY), 0);
            @(posedge ACLK); #1;
        end
        AWVALID = 1; AWADDR = 4'h8;
        @(negedge ACLK); chk("t3_awready", 32'(AWREADY), 1);
        @(posedge ACLK); #1 AWVALID = 0;
        model_write(4'h8, 32'h5a5a5a5a, 4'hf);
        @(negedge ACLK); chk("t3_bvalid_early", 32'(BVALID), 0);
        @(negedge ACLK); chk("t3_bvalid", 32'(BVALID), 1);
        @(posedge ACLK); #1;
        chk_regout();
        read(4'h8);

        // Response back-pressure on both channels
        BREADY = 0;
        wr_req(4'h0, 32'h01020304, 4'hf, 0, 0);
        @(posedge ACLK); #1;
        repeat (5) begin
            @(negedge ACLK);
            chk("t4_bvalid_hold", 32'(BVALID), 1);
            chk("t4_awready_low", 32'(AWREADY), 0);
            chk("t4_wready_low", 32'(WREADY), 0);
        end
        @(posedge ACLK); #1;
        wait_b(0);
        write(4'h4, 32'hcafef00d, 4'hf);
        RREADY = 0;
        rd_req(4'h8);
        repeat (5) begin
            @(negedge ACLK);
            chk("t4_rvalid_hold", 32'(RVALID), 1);
            chk("t4_rdata_hold", RDATA, model[2]);
        end
        @(posedge ACLK); #1;
        wait_r(0);

        // Read handshake on the same edge as a write commit to the same register
        write(4'hC, 32'hbeef0011, 4'hf);
        AWVALID = 1; AWADDR = 4'hC; WVALID = 1; WDATA = 32'h12345678; WSTRB = 4'hf;
        @(negedge ACLK);
        chk("t5_awready", 32'(AWREADY), 1);
        chk("t5_wready", 32'(WREADY), 1);
        @(posedge ACLK); #1 AWVALID = 0; WVALID = 0; ARVALID = 1; ARADDR = 4'hC;
        @(negedge ACLK); chk("t5_arready", 32'(ARREADY), 1);
        rq.push_back(model[3]);
        model_write(4'hC, 32'h12345678, 4'hf);
        @(posedge ACLK); #1 ARVALID = 0;
        repeat (3) begin @(posedge ACLK); #1; end
        read(4'hC);
        chk_regout();

        for (int n = 0; n < 60; n++) begin
            a = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                wr_req(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
                wait_b($urandom_range(0, 3));
                chk_regout();
            end else begin
                rd_req(a);
                wait_r($urandom_range(0, 3));
            end
        end

        // Asynchronous reset with AW latched and W still pending
        AWVALID = 1; AWADDR = 4'h4;
        @(posedge ACLK); #1 AWVALID = 0; WVALID = 1; WDATA = 32'hffffffff; WSTRB = 4'hf;
        #2 ARESETN = 0;
        bq = 0; sq.delete(); rq.delete();
        for (int k = 0; k < N; k++) model[k] = '0;
        #1 chk_idle_zero("async_rst");
        WVALID = 0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK); #2 ARESETN = 1;
        repeat (6) begin @(negedge ACLK); chk("post_rst_bvalid", 32'(BVALID), 0); end
        @(posedge ACLK); #1;
        for (int k = 0; k < N; k++) read(AW'(4 * k));
        chk_regout();

        repeat (3) @(posedge ACLK);
        chk("b_pending", 32'(bq), 0);
        chk("r_pending", 32'(rq.size()), 0);
        chk("stb_pending", 32'(sq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
